// File: rtl/mem_bridge.sv
// rtl/mem_bridge.sv - single-transaction CPU load/store to word-bus bridge with timeout
// Optional misaligned-access trap enabled by defining MISALIGN_TRAP_EN.
module mem_bridge #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] cpu_address,
  input  logic        cpu_read_enable,
  input  logic        cpu_write_enable,
  input  logic [31:0] cpu_write_data,
  input  logic [1:0]  cpu_wstrb,
  output logic [31:0] cpu_read_data,
  output logic        cpu_stall,
  output logic        cpu_misaligned,
  output logic        bus_error,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_resp_valid,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Counter may overshoot the limit by one when the handshake lands on the last REQ cycle.
  localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    state;
  logic [1:0]    size_q;
  logic [1:0]    offset_q;
  logic [CW-1:0] counter;

  logic          request;
  logic          misaligned;
  logic [1:0]    req_off;
  logic [3:0]    req_be;
  logic [31:0]   rdata_shifted;
  logic [31:0]   rdata_aligned;

  assign request = cpu_read_enable | cpu_write_enable;

  // Lane selection uses the lowest enabled byte, so sub-size offset bits are dropped.
  always_comb begin
    req_off = cpu_address[1:0];
    req_be  = 4'b0001 << cpu_address[1:0];
    if (cpu_wstrb[1]) begin
      req_off = 2'b00;
      req_be  = 4'b1111;
    end else if (cpu_wstrb[0]) begin
      req_off = {cpu_address[1], 1'b0};
      req_be  = 4'b0011 << {cpu_address[1], 1'b0};
    end
  end

`ifdef MISALIGN_TRAP_EN
  assign misaligned = cpu_wstrb[1] ? (cpu_address[1:0] != 2'b00)
                                   : (cpu_wstrb[0] & cpu_address[0]);
`else
  assign misaligned = 1'b0;
`endif

  assign rdata_shifted = bus_rdata >> {offset_q, 3'b000};

  always_comb begin
    rdata_aligned = rdata_shifted;
    case (size_q)
      2'b00:   rdata_aligned = {24'd0, rdata_shifted[7:0]};
      2'b01:   rdata_aligned = {16'd0, rdata_shifted[15:0]};
      default: rdata_aligned = rdata_shifted;
    endcase
  end

  assign bus_req_valid = (state == S_REQ);
  assign cpu_stall     = !reset && (((state == S_IDLE) && request) ||
                                    (state == S_REQ) || (state == S_RESP));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      size_q         <= 2'b00;
      offset_q       <= 2'b00;
      counter        <= '0;
      bus_addr       <= 32'd0;
      bus_we         <= 1'b0;
      bus_wdata      <= 32'd0;
      bus_be         <= 4'd0;
      cpu_read_data  <= 32'd0;
      bus_error      <= 1'b0;
      cpu_misaligned <= 1'b0;
    end else begin
      bus_error      <= 1'b0;
      cpu_misaligned <= 1'b0;
      case (state)
        S_IDLE: begin
          if (request) begin
            if (misaligned) begin
              cpu_misaligned <= 1'b1;
              cpu_read_data  <= 32'd0;
              state          <= S_DONE;
            end else begin
              bus_addr  <= {cpu_address[31:2], 2'b00};
              bus_we    <= cpu_write_enable;
              bus_be    <= req_be;
              bus_wdata <= cpu_write_data << {req_off, 3'b000};
              size_q    <= cpu_wstrb;
              offset_q  <= req_off;
              counter   <= '0;
              state     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          counter <= counter + 1'b1;
          if (bus_req_ready) begin
            state <= S_RESP;
          end else if (counter >= LAST) begin
            bus_error     <= 1'b1;
            cpu_read_data <= 32'd0;
            state         <= S_DONE;
          end
        end
        S_RESP: begin
          counter <= counter + 1'b1;
          if (bus_resp_valid) begin
            if (!bus_we) cpu_read_data <= rdata_aligned;
            state <= S_DONE;
          end else if (counter >= LAST) begin
            bus_error     <= 1'b1;
            cpu_read_data <= 32'd0;
            state         <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
